// File: rtl/reg_file.sv
// reg_file: 32 x 64-bit RISC-V general-purpose register file (x0..x31).
//
// Two combinational read ports and one synchronous write port. x0 is
// hardwired to zero: writes to address 0 are dropped and reads of address 0
// return 0. There is no write-to-read bypass; a read of the register being
// written shows the old value until the clock edge commits the write.
//
// Ports:
//   clock       in   system clock, writes commit on the rising edge
//   reset       in   asynchronous active-low reset, clears every register
//   read_reg1   in   [ADDR_WIDTH-1:0] read port 1 address
//   read_reg2   in   [ADDR_WIDTH-1:0] read port 2 address
//   write_reg   in   [ADDR_WIDTH-1:0] write port address
//   write_data  in   [DATA_WIDTH-1:0] write data
//   reg_write   in   write enable, active-high
//   read_data1  out  [DATA_WIDTH-1:0] contents of register read_reg1
//   read_data2  out  [DATA_WIDTH-1:0] contents of register read_reg2
module reg_file #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];

    // Next-state: copy current contents, apply the single enabled write,
    // then pin x0 to zero so it never holds anything but 0.
    always_comb begin
        regs_d = regs_q;
        if (reg_write && (write_reg != '0)) begin
            regs_d[write_reg] = write_data;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Address 0 is decoded explicitly so x0 reads 0 independent of storage.
    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        if (read_reg1 != '0) begin
            read_data1 = regs_q[read_reg1];
        end
        if (read_reg2 != '0) begin
            read_data2 = regs_q[read_reg2];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

    logic        clock;
    logic        reset;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [63:0] write_data;
    logic        reg_write;
    logic [63:0] read_data1;
    logic [63:0] read_data2;

    int checks;
    int errors;

    reg_file #(
        .DATA_WIDTH(64),
        .ADDR_WIDTH(5)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .reg_write  (reg_write),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single write: inputs change on the falling edge, commit on the next
    // rising edge, enable dropped on the following falling edge.
    task automatic do_write(input logic [4:0] addr, input logic [63:0] data);
        @(negedge clock);
        write_reg  = addr;
        write_data = data;
        reg_write  = 1'b1;
        @(negedge clock);
        reg_write  = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] a;
        for (int i = 0; i < 32; i++) begin
            a = 5'(i);
            read_reg1 = a;
            read_reg2 = a;
            #1;
            checks++;
            if (read_data1 !== 64'd0) begin
                errors++;
                $display("FAIL reset_rd1[%0d]: got %h expected %h", i, read_data1, 64'd0);
            end
            checks++;
            if (read_data2 !== 64'd0) begin
                errors++;
                $display("FAIL reset_rd2[%0d]: got %h expected %h", i, read_data2, 64'd0);
            end
        end
    endtask

    task automatic test_write_sweep();
        logic [63:0] exp1;
        logic [63:0] exp2;
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            write_reg  = 5'(i);
            write_data = 64'(i);
            reg_write  = 1'b1;
        end
        @(negedge clock);
        reg_write = 1'b0;
        for (int i = 0; i < 32; i += 2) begin
            read_reg1 = 5'(i);
            read_reg2 = 5'(i + 1);
            exp1 = (i == 0) ? 64'd0 : 64'(i);
            exp2 = 64'(i + 1);
            #1;
            checks++;
            if (read_data1 !== exp1) begin
                errors++;
                $display("FAIL sweep_rd1[%0d]: got %h expected %h", i, read_data1, exp1);
            end
            checks++;
            if (read_data2 !== exp2) begin
                errors++;
                $display("FAIL sweep_rd2[%0d]: got %h expected %h", i + 1, read_data2, exp2);
            end
        end
        // Both ports on the same register.
        read_reg1 = 5'd5;
        read_reg2 = 5'd5;
        #1;
        checks++;
        if (read_data1 !== 64'd5 || read_data2 !== 64'd5) begin
            errors++;
            $display("FAIL same_addr: got %h/%h expected %h", read_data1, read_data2, 64'd5);
        end
    endtask

    task automatic test_x0();
        do_write(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        read_reg1 = 5'd0;
        read_reg2 = 5'd0;
        #1;
        checks++;
        if (read_data1 !== 64'd0) begin
            errors++;
            $display("FAIL x0_rd1: got %h expected %h", read_data1, 64'd0);
        end
        checks++;
        if (read_data2 !== 64'd0) begin
            errors++;
            $display("FAIL x0_rd2: got %h expected %h", read_data2, 64'd0);
        end
    endtask

    task automatic test_write_enable();
        do_write(5'd7, 64'hA5);
        read_reg1 = 5'd7;
        #1;
        checks++;
        if (read_data1 !== 64'hA5) begin
            errors++;
            $display("FAIL we_written: got %h expected %h", read_data1, 64'hA5);
        end
        @(negedge clock);
        write_reg  = 5'd7;
        write_data = 64'h3C;
        reg_write  = 1'b0;
        repeat (4) @(negedge clock);
        checks++;
        if (read_data1 !== 64'hA5) begin
            errors++;
            $display("FAIL we_blocked: got %h expected %h", read_data1, 64'hA5);
        end
    endtask

    task automatic test_read_during_write();
        do_write(5'd9, 64'd1);
        read_reg1 = 5'd9;
        @(negedge clock);
        write_reg  = 5'd9;
        write_data = 64'd2;
        reg_write  = 1'b1;
        #1;
        checks++;
        if (read_data1 !== 64'd1) begin
            errors++;
            $display("FAIL rdw_before: got %h expected %h", read_data1, 64'd1);
        end
        @(posedge clock);
        #1;
        checks++;
        if (read_data1 !== 64'd2) begin
            errors++;
            $display("FAIL rdw_after: got %h expected %h", read_data1, 64'd2);
        end
        @(negedge clock);
        reg_write = 1'b0;
    endtask

    task automatic test_async_reset();
        // Registers 9 (=2) and 31 (=31) are nonzero from earlier tests.
        read_reg1 = 5'd9;
        read_reg2 = 5'd31;
        @(negedge clock);
        write_reg  = 5'd3;
        write_data = 64'hDEAD_BEEF;
        reg_write  = 1'b1;
        #1;
        checks++;
        if (read_data1 !== 64'd2 || read_data2 !== 64'd31) begin
            errors++;
            $display("FAIL arst_pre: got %h/%h expected %h/%h", read_data1, read_data2, 64'd2, 64'd31);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (read_data1 !== 64'd0 || read_data2 !== 64'd0) begin
            errors++;
            $display("FAIL arst_immediate: got %h/%h expected 0/0", read_data1, read_data2);
        end
        // Write stays enabled across a rising edge while reset is held.
        @(posedge clock);
        #1;
        read_reg1 = 5'd3;
        #1;
        checks++;
        if (read_data1 !== 64'd0) begin
            errors++;
            $display("FAIL arst_write_blocked: got %h expected %h", read_data1, 64'd0);
        end
        for (int i = 0; i < 32; i++) begin
            read_reg2 = 5'(i);
            #1;
            checks++;
            if (read_data2 !== 64'd0) begin
                errors++;
                $display("FAIL arst_clear[%0d]: got %h expected %h", i, read_data2, 64'd0);
            end
        end
        @(negedge clock);
        reg_write = 1'b0;
        reset     = 1'b1;
        do_write(5'd4, 64'h1234_5678_9ABC_DEF0);
        read_reg1 = 5'd4;
        #1;
        checks++;
        if (read_data1 !== 64'h1234_5678_9ABC_DEF0) begin
            errors++;
            $display("FAIL arst_resume: got %h expected %h", read_data1, 64'h1234_5678_9ABC_DEF0);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        read_reg1  = '0;
        read_reg2  = '0;
        write_reg  = '0;
        write_data = '0;
        reg_write  = 1'b0;
        #1;
        reset = 1'b1;

        test_reset();
        test_write_sweep();
        test_x0();
        test_write_enable();
        test_read_during_write();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
